// File: rtl/crossbar_shift_sched_if.sv
// Handshake bundle between the shift-crossbar sequencer and its job source,
// upstream beat source, crossbar control and downstream accumulator.
interface crossbar_shift_sched_if #(
  parameter int TS_WIDTH  = 3,
  parameter int CNT_WIDTH = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [TS_WIDTH-1:0]  cfg_num_shifts;
  logic [CNT_WIDTH-1:0] cfg_num_groups;
  logic                 in_valid;
  logic                 in_ready;
  logic                 xbar_clk_en;
  logic [TS_WIDTH-1:0]  xbar_timestamp;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  modport master (
    output cfg_valid, cfg_num_shifts, cfg_num_groups, in_valid, out_ready,
    input  cfg_ready, in_ready, xbar_clk_en, xbar_timestamp, out_valid,
           out_last, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_num_shifts, cfg_num_groups, in_valid, out_ready,
    output cfg_ready, in_ready, xbar_clk_en, xbar_timestamp, out_valid,
           out_last, busy, done
  );
endinterface

// File: rtl/crossbar_shift_sched.sv
// Sequencer for the conv shift crossbar: paces input beats, drives clock enable
// and timestamp, and tracks the crossbar's one-cycle registered output.
module crossbar_shift_sched #(
  parameter int TS_WIDTH  = 3,
  parameter int CNT_WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  crossbar_shift_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [CNT_WIDTH-1:0] GRP_ONE = CNT_WIDTH'(1);

  state_t               state;
  logic [TS_WIDTH-1:0]  ts, shifts_q;
  logic [CNT_WIDTH-1:0] grp, groups_q;
  logic                 out_valid_q, out_last_q, done_q;
  logic                 in_ready, fire, grp_end, final_beat;

  // One-deep output slot: a new beat may enter whenever the slot frees this cycle.
  always_comb begin
    in_ready   = (state == RUN) && (!out_valid_q || bus.out_ready);
    fire       = bus.in_valid && in_ready;
    grp_end    = (ts == shifts_q);
    final_beat = grp_end && (grp == groups_q - GRP_ONE);
  end

  assign bus.cfg_ready      = (state == IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.in_ready       = in_ready;
  assign bus.xbar_clk_en    = fire;
  assign bus.xbar_timestamp = ts;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_last       = out_last_q;
  assign bus.done           = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ts          <= '0;
      grp         <= '0;
      shifts_q    <= '0;
      groups_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Output register mirrors the crossbar's own registered result.
      if (fire) begin
        out_valid_q <= 1'b1;
        out_last_q  <= final_beat;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      case (state)
        IDLE: if (bus.cfg_valid) begin
          shifts_q <= bus.cfg_num_shifts;
          groups_q <= bus.cfg_num_groups;
          ts       <= '0;
          grp      <= '0;
          state    <= (bus.cfg_num_groups == '0) ? FIN : RUN;
        end
        RUN: if (fire) begin
          if (grp_end) begin
            ts  <= '0;
            grp <= grp + GRP_ONE;
          end else begin
            ts <= ts + 1'b1;
          end
          if (final_beat) state <= DRAIN;
        end
        DRAIN: if (!out_valid_q || bus.out_ready) state <= FIN;
        FIN: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crossbar_shift_sched.sv
// Directed bench for crossbar_shift_sched: each step drives one cycle's inputs
// and compares every observable output against hand-derived values.
module tb_crossbar_shift_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  crossbar_shift_sched_if #(.TS_WIDTH(3), .CNT_WIDTH(16)) bus ();

  crossbar_shift_sched #(.TS_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample mid-cycle.
  task automatic cyc(input string tag, input bit cv, input bit iv, input bit ordy,
                     input bit en, input logic [2:0] ts, input bit ov, input bit ol,
                     input bit dn, input bit bsy);
    @(posedge clk);
    #1;
    bus.cfg_valid = cv;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    #1;
    chk({tag, ".en"},    32'(bus.xbar_clk_en),    32'(en));
    chk({tag, ".ts"},    32'(bus.xbar_timestamp), 32'(ts));
    chk({tag, ".ov"},    32'(bus.out_valid),      32'(ov));
    chk({tag, ".ol"},    32'(bus.out_last),       32'(ol));
    chk({tag, ".done"},  32'(bus.done),           32'(dn));
    chk({tag, ".busy"},  32'(bus.busy),           32'(bsy));
    chk({tag, ".cfgrd"}, 32'(bus.cfg_ready),      32'(!bsy));
  endtask

  initial begin
    bus.cfg_valid      = 1'b0;
    bus.cfg_num_shifts = 3'd0;
    bus.cfg_num_groups = 16'd0;
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b0;

    // Reset values
    #2;
    chk("rst.ov",    32'(bus.out_valid),      32'd0);
    chk("rst.ol",    32'(bus.out_last),       32'd0);
    chk("rst.done",  32'(bus.done),           32'd0);
    chk("rst.busy",  32'(bus.busy),           32'd0);
    chk("rst.en",    32'(bus.xbar_clk_en),    32'd0);
    chk("rst.ts",    32'(bus.xbar_timestamp), 32'd0);
    chk("rst.inrd",  32'(bus.in_ready),       32'd0);
    chk("rst.cfgrd", 32'(bus.cfg_ready),      32'd1);
    #10 rst_n = 1'b1;

    // Basic job: shifts=3 (4 per group), groups=2, continuous flow
    bus.cfg_num_shifts = 3'd3; bus.cfg_num_groups = 16'd2;
    //          tag     cv iv or en ts ov ol dn bsy
    cyc("b0",  1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("b1",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("b2",  0, 1, 1, 1, 1, 1, 0, 0, 1);
    cyc("b3",  0, 1, 1, 1, 2, 1, 0, 0, 1);
    cyc("b4",  0, 1, 1, 1, 3, 1, 0, 0, 1);
    cyc("b5",  0, 1, 1, 1, 0, 1, 0, 0, 1);
    cyc("b6",  0, 1, 1, 1, 1, 1, 0, 0, 1);
    cyc("b7",  0, 1, 1, 1, 2, 1, 0, 0, 1);
    cyc("b8",  0, 1, 1, 1, 3, 1, 0, 0, 1);
    chk("b8.inrd", 32'(bus.in_ready), 32'd1);
    cyc("b9",  0, 1, 1, 0, 0, 1, 1, 0, 1);
    chk("b9.inrd", 32'(bus.in_ready), 32'd0);
    cyc("b10", 0, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc("b11", 0, 0, 1, 0, 0, 0, 0, 1, 0);
    cyc("b12", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Backpressure: shifts=1, groups=3, out_ready low 4 cycles after 2nd output
    bus.cfg_num_shifts = 3'd1; bus.cfg_num_groups = 16'd3;
    cyc("p0",  1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("p1",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("p2",  0, 1, 1, 1, 1, 1, 0, 0, 1);
    cyc("p3",  0, 1, 1, 1, 0, 1, 0, 0, 1);
    cyc("p4",  0, 1, 0, 0, 1, 1, 0, 0, 1);
    chk("p4.inrd", 32'(bus.in_ready), 32'd0);
    cyc("p5",  0, 1, 0, 0, 1, 1, 0, 0, 1);
    cyc("p6",  0, 1, 0, 0, 1, 1, 0, 0, 1);
    cyc("p7",  0, 1, 0, 0, 1, 1, 0, 0, 1);
    cyc("p8",  0, 1, 1, 1, 1, 1, 0, 0, 1);
    cyc("p9",  0, 1, 1, 1, 0, 1, 0, 0, 1);
    cyc("p10", 0, 1, 1, 1, 1, 1, 0, 0, 1);
    cyc("p11", 0, 1, 1, 0, 0, 1, 1, 0, 1);
    cyc("p12", 0, 0, 1, 0, 0, 0, 0, 0, 1);
    cyc("p13", 0, 0, 1, 0, 0, 0, 0, 1, 0);

    // Empty job: groups=0 goes straight through FIN
    bus.cfg_num_shifts = 3'd5; bus.cfg_num_groups = 16'd0;
    cyc("e0",  1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("e1",  0, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc("e2",  0, 1, 1, 0, 0, 0, 0, 1, 0);
    cyc("e3",  0, 0, 1, 0, 0, 0, 0, 0, 0);

    // shifts=0, groups=5, in_valid toggling
    bus.cfg_num_shifts = 3'd0; bus.cfg_num_groups = 16'd5;
    cyc("z0",  1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("z1",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("z2",  0, 0, 1, 0, 0, 1, 0, 0, 1);
    cyc("z3",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("z4",  0, 0, 1, 0, 0, 1, 0, 0, 1);
    cyc("z5",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("z6",  0, 0, 1, 0, 0, 1, 0, 0, 1);
    cyc("z7",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("z8",  0, 0, 1, 0, 0, 1, 0, 0, 1);
    cyc("z9",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("z10", 0, 0, 1, 0, 0, 1, 1, 0, 1);
    cyc("z11", 0, 0, 1, 0, 0, 0, 0, 0, 1);
    cyc("z12", 0, 0, 1, 0, 0, 0, 0, 1, 0);

    // Reset mid-job after 3 of 8 beats
    bus.cfg_num_shifts = 3'd3; bus.cfg_num_groups = 16'd2;
    cyc("r0",  1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("r1",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("r2",  0, 1, 1, 1, 1, 1, 0, 0, 1);
    cyc("r3",  0, 1, 1, 1, 2, 1, 0, 0, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("ra.ov",    32'(bus.out_valid),      32'd0);
    chk("ra.ol",    32'(bus.out_last),       32'd0);
    chk("ra.busy",  32'(bus.busy),           32'd0);
    chk("ra.ts",    32'(bus.xbar_timestamp), 32'd0);
    chk("ra.en",    32'(bus.xbar_clk_en),    32'd0);
    chk("ra.cfgrd", 32'(bus.cfg_ready),      32'd1);
    chk("ra.done",  32'(bus.done),           32'd0);
    #3 rst_n = 1'b1;
    cyc("r4",  0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("r5",  0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("r6",  0, 0, 1, 0, 0, 0, 0, 0, 0);
    bus.cfg_num_shifts = 3'd2; bus.cfg_num_groups = 16'd1;
    cyc("n0",  1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("n1",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("n2",  0, 1, 1, 1, 1, 1, 0, 0, 1);
    cyc("n3",  0, 1, 1, 1, 2, 1, 0, 0, 1);
    cyc("n4",  0, 1, 1, 0, 0, 1, 1, 0, 1);
    cyc("n5",  0, 0, 1, 0, 0, 0, 0, 0, 1);
    cyc("n6",  0, 0, 1, 0, 0, 0, 0, 1, 0);

    // cfg_valid held through a job: new config taken only back in IDLE
    bus.cfg_num_shifts = 3'd1; bus.cfg_num_groups = 16'd1;
    cyc("h0",  1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("h1",  1, 1, 1, 1, 0, 0, 0, 0, 1);
    bus.cfg_num_shifts = 3'd3;
    cyc("h2",  1, 1, 1, 1, 1, 1, 0, 0, 1);
    cyc("h3",  1, 1, 1, 0, 0, 1, 1, 0, 1);
    cyc("h4",  1, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc("h5",  1, 1, 1, 0, 0, 0, 0, 1, 0);
    cyc("h6",  0, 1, 1, 1, 0, 0, 0, 0, 1);
    cyc("h7",  0, 1, 1, 1, 1, 1, 0, 0, 1);
    cyc("h8",  0, 1, 1, 1, 2, 1, 0, 0, 1);
    cyc("h9",  0, 1, 1, 1, 3, 1, 0, 0, 1);
    cyc("h10", 0, 0, 1, 0, 0, 1, 1, 0, 1);
    cyc("h11", 0, 0, 1, 0, 0, 0, 0, 0, 1);
    cyc("h12", 0, 0, 1, 0, 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
